mesh_inj_arbiter: RTL
=====================

Name: mesh_inj_arbiter

Overview:
Round-robin scheduler that shares one mesh_gnrtr terminal input port (pndng_i_in / data_out_i_in / popin) among NREQ packet sources. Each source is a fall-through FIFO.
- Picks a winner, pops its head packet and latches it.
- Checks the destination field, then offers the packet to the router until the router pops it.
- Sits between the per-terminal FIFO stage and the router terminal port.

Parameters:
NREQ, 4, number of requester FIFOs sharing the port (2..8)
pckg_sz, 40, packet width in bits
ROWS, 4, mesh rows; legal destination row is 0..ROWS+1
COLUMS, 4, mesh columns; legal destination column is 0..COLUMS+1
TMO, 255, number of OFFER cycles without popin before tmo_err asserts (8-bit counter)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_pndng  in  NREQ  bit i high: FIFO i head packet valid
req_data  in  NREQ*pckg_sz  FIFO i head packet at bits [i*pckg_sz +: pckg_sz]
req_pop  out  NREQ  one-hot pop to the winning FIFO; combinational
pndng_i_in  out  1  packet offered to the router; registered
data_out_i_in  out  pckg_sz  offered packet; registered
popin  in  1  router consumed the offered packet this cycle
grant  out  NREQ  one-hot index of the owner of the held packet; registered
busy  out  1  high in OFFER
drop  out  1  one-cycle pulse: packet discarded for an illegal destination
tmo_err  out  1  sticky until reset: TMO reached in OFFER
grant_cnt  out  NREQ*16  per-requester accepted-packet counters (optional feature)

Behaviour:
- Packet fields:
  - Nxtjp = [pckg_sz-1:pckg_sz-8]
  - row = [pckg_sz-9:pckg_sz-12]
  - col = [pckg_sz-13:pckg_sz-16]
  - mode = [pckg_sz-17]
  - payload = [pckg_sz-18:0]
- Reset values: state=IDLE, pndng_i_in=0, data_out_i_in=0, grant=0, busy=0, drop=0, tmo_err=0, last=NREQ-1 (so requester 0 wins first), timeout counter=0.
- FSM states:
  - IDLE: if no req_pndng, stay. Otherwise winner = first set bit scanning from (last+1) mod NREQ upward with wrap. In the same cycle req_pop[winner]=1 and req_data slice is captured; last<=winner.
    - Legal destination (row<=ROWS+1 and col<=COLUMS+1): go to OFFER. data_out_i_in <= captured packet with Nxtjp forced to 0; pndng_i_in<=1; grant<=onehot(winner).
    - Illegal destination: drop<=1 for one cycle; stay IDLE; arbitration restarts next cycle from the updated last.
  - OFFER: pndng_i_in=1 and data_out_i_in stable; req_pop all 0.
    - popin=1: next cycle pndng_i_in=0, grant=0, state IDLE.
    - popin=0: counter++ (saturating). When counter==TMO, tmo_err<=1. The packet is never abandoned; stay in OFFER.
- Throughput: at most one packet per 2 cycles (IDLE pop, OFFER with immediate popin).
- Latency: req_pndng rises at cycle t with the arbiter idle → req_pop at t → pndng_i_in at t+1.
- popin while not in OFFER: ignored.
- req_pndng deasserting in OFFER: no effect; the packet is already held.
- Single requester: that requester wins every IDLE; no bubbles beyond the 2-cycle minimum.
- Reset mid-OFFER: held packet is lost; pndng_i_in=0 the cycle after reset is sampled. Arbitration pointer resets.
- Counter clears on entry to OFFER.

Optional Feature:
MESH_ARB_STATS_EN
- Defined: grant_cnt[i*16 +: 16] increments (saturating at 16'hFFFF) on every popin accepted for requester i. Dropped packets are not counted. Cleared by reset.
- Undefined: grant_cnt tied to 0; no counter flops.

Test Plan:
1. Reset held 5 cycles, then released with req_pndng=4'b1111 → first grant=0001, then 0010, 0100, 1000, 0001 (popin held high). One pndng_i_in pulse per 2 cycles.
2. req_pndng=4'b0101, popin=1 → grants alternate 0001/0100; req_pop never hits bits 1 or 3.
3. Requester 2 packet with row=7 (ROWS=4) → req_pop[2]=1, drop pulses once, pndng_i_in stays 0, next IDLE scans from requester 3.
4. Legal packet with Nxtjp=8'hAB, row=2, col=0, payload=1 → data_out_i_in has Nxtjp=0 and other fields unchanged. popin held 0 for 256 cycles → tmo_err=1 at the 255th waiting cycle. pndng_i_in stays 1; popin=1 completes the transfer.
5. Reset asserted during OFFER → pndng_i_in=0 next cycle, tmo_err=0, next grant goes to requester 0.
6. With MESH_ARB_STATS_EN and 10 accepted packets from requester 1 plus 3 drops → grant_cnt[31:16]=10. Without the macro → grant_cnt=0.

Source files
------------

// File: rtl/mesh_inj_arbiter.sv
// Round-robin injector: shares one mesh router terminal port among NREQ fall-through FIFOs.
// Optional per-requester accepted-packet counters are enabled by defining MESH_ARB_STATS_EN.
module mesh_inj_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned pckg_sz = 40,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLUMS  = 4,
    parameter int unsigned TMO     = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_pndng,
    input  logic [NREQ*pckg_sz-1:0]   req_data,
    output logic [NREQ-1:0]           req_pop,
    output logic                      pndng_i_in,
    output logic [pckg_sz-1:0]        data_out_i_in,
    input  logic                      popin,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output logic                      drop,
    output logic                      tmo_err,
    output logic [NREQ*16-1:0]        grant_cnt
);

    localparam int unsigned IW      = $clog2(NREQ);
    localparam logic [3:0]  MaxRow  = 4'(ROWS + 1);
    localparam logic [3:0]  MaxCol  = 4'(COLUMS + 1);
    localparam logic [7:0]  TmoVal  = 8'(TMO);
    localparam logic [IW-1:0] LastRst = IW'(NREQ - 1);

    typedef enum logic {StIdle, StOffer} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [pckg_sz-1:0]  data_q, data_d;
    logic                pndng_q, pndng_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                drop_q, drop_d;
    logic                tmo_q, tmo_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [NREQ-1:0]     win_oh;
    logic [IW-1:0]       win_idx;
    logic                any_req;
    logic [pckg_sz-1:0]  cap;
    logic                legal;
    logic                accept;

    // Scan downward so the lowest offset from last+1 is assigned last and wins.
    always_comb begin
        int unsigned idx;
        logic [IW-1:0] idx_w;
        idx     = 0;
        idx_w   = '0;
        win_idx = '0;
        win_oh  = '0;
        any_req = |req_pndng;
        for (int i = NREQ; i >= 1; i--) begin
            idx   = (int'(last_q) + i) % NREQ;
            idx_w = IW'(idx);
            if (req_pndng[idx_w]) begin
                win_idx = idx_w;
            end
        end
        win_oh[win_idx] = any_req;
    end

    always_comb begin
        cap = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                cap = req_data[i*pckg_sz +: pckg_sz];
            end
        end
        legal = (cap[pckg_sz-9 -: 4] <= MaxRow) && (cap[pckg_sz-13 -: 4] <= MaxCol);
    end

    assign accept = (state_q == StOffer) && popin;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        pndng_d = pndng_q;
        grant_d = grant_q;
        drop_d  = 1'b0;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        req_pop = '0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    req_pop = win_oh;
                    last_d  = win_idx;
                    if (legal) begin
                        state_d = StOffer;
                        data_d  = {8'h00, cap[pckg_sz-9:0]};
                        pndng_d = 1'b1;
                        grant_d = win_oh;
                        cnt_d   = '0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
            end
            StOffer: begin
                if (popin) begin
                    state_d = StIdle;
                    pndng_d = 1'b0;
                    grant_d = '0;
                end else begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_d == TmoVal) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= LastRst;
            data_q  <= '0;
            pndng_q <= 1'b0;
            grant_q <= '0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            pndng_q <= pndng_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pndng_i_in    = pndng_q;
    assign data_out_i_in = data_q;
    assign grant         = grant_q;
    assign busy          = (state_q == StOffer);
    assign drop          = drop_q;
    assign tmo_err       = tmo_q;

`ifdef MESH_ARB_STATS_EN
    logic [NREQ*16-1:0] gcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && grant_q[i] && (gcnt_q[i*16 +: 16] != 16'hFFFF)) begin
                    gcnt_q[i*16 +: 16] <= gcnt_q[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = gcnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign grant_cnt     = '0;
`endif

endmodule
